reg_access_ctrl: RTL
====================

// Module: reg_access_ctrl
// PURPOSE
//  Debug-side initiator for the 32x32 register file's read port A and write port.
//  Accepts single read/write commands over a valid/ready interface.
//  Halts the core via halt_req/halted, performs the access, then returns a response.
//  Sits between the debug transport and the register file, muxed in front of the core's writeback port.
// PARAMETERS
//  XLEN          32   data width of register file
//  AW            5    register address width
//  HALT_TIMEOUT  64   cycles to wait for halted before aborting (>=2)
// PORTS
//  clk_Regs    in   1     register-file clock; all state updates on posedge
//  rst_Regs    in   1     synchronous, active-high reset
//  cmd_valid   in   1     command present
//  cmd_ready   out  1     command accepted when valid&ready
//  cmd_write   in   1     1=write, 0=read
//  cmd_addr    in   AW    target register
//  cmd_data    in   XLEN  write data
//  cmd_count   in   AW    extra accesses minus 0 (used only with REG_ACCESS_BURST_EN)
//  rsp_valid   out  1     response present; held until rsp_ready
//  rsp_ready   in   1     response consumed
//  rsp_data    out  XLEN  read data (0 for writes/errors)
//  rsp_err     out  1     1=timeout or write to x0
//  halt_req    out  1     request core halt
//  halted      in   1     core is halted and its regfile port is idle
//  Reg_Write   out  1     regfile write enable
//  W_Addr      out  AW    regfile write address
//  W_Data      out  XLEN  regfile write data
//  R_Addr_A    out  AW    regfile read address A
//  R_Data_A    in   XLEN  regfile read data A (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE; cmd_ready=1, all other outputs 0; timer cleared. Reset mid-op aborts silently (no rsp).
//  FSM IDLE -> HALT_WAIT -> ACCESS -> RESP -> IDLE.
//  IDLE: cmd_ready=1; on cmd_valid latch write/addr/data/count; next HALT_WAIT. cmd_ready=0 elsewhere.
//  HALT_WAIT: halt_req=1; timer counts from 0; halted sampled =1 -> ACCESS (min 1 cycle here even if
//   already halted); timer reaches HALT_TIMEOUT-1 without halted -> RESP, rsp_err=1, rsp_data=0, no access.
//  ACCESS (exactly 1 cycle, halt_req=1): write: W_Addr=addr, W_Data=data, Reg_Write=1 unless addr==0
//   (then Reg_Write=0, rsp_err=1). read: R_Addr_A=addr, R_Data_A registered into rsp_data at cycle end.
//   Reg_Write is 1 for only this single cycle.
//  RESP: rsp_valid=1, rsp_data/rsp_err stable; halt_req stays 1; on rsp_ready -> IDLE, halt_req=0 next cycle.
//  Latency with halted=1 and rsp_ready=1: accept edge +3 cycles to rsp handshake.
//  Read of x0 returns R_Data_A unmodified (the regfile guarantees 0); no error.
//  R_Addr_A/W_Addr/W_Data hold last value outside ACCESS; only Reg_Write is qualified.
// CONFIGURATION
//  REG_ACCESS_BURST_EN defined: after RESP handshake, if remaining count>0, addr<=addr+1,
//   count<=count-1, go directly to ACCESS (halt kept, no HALT_WAIT); one response per access.
//   Address increment past 31 is not performed: burst ends with that rsp, rsp_err=1.
//   Writes repeat the same cmd_data.
//  Undefined: cmd_count ignored; every command does exactly one access.
// STRUCTURE
//  Package reg_access_pkg: XLEN/AW localparams, state encoding (IDLE, HALT_WAIT, ACCESS, RESP).
//  Sub-module reg_access_halt_timer: counter with clear/enable and expired flag (HALT_TIMEOUT).
//  Top instantiates the regfile only in the bench, never inside this block.
// TESTING
//  Write x5=0xFEDCBA98, halted=1 -> Reg_Write pulses 1 cycle, W_Addr=5, rsp_err=0, rsp_data=0.
//  Read x5 after above -> R_Addr_A=5, rsp_data=0xFEDCBA98, rsp_err=0.
//  Write x0=0x07643210 -> Reg_Write never 1, rsp_err=1; subsequent read x0 returns 0.
//  halted held 0 -> halt_req=1 for 64 cycles, then rsp_err=1, no regfile strobe; halted asserted late
//   (cycle 10) -> access completes normally.
//  rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0; rst_Regs mid-RESP -> all 0.
//  BURST_EN: read addr=30 count=3 -> rsps for x30, x31 (err=1), burst ends; no access to x0.

Source files
------------

// File: rtl/reg_access_pkg.sv
// Shared widths and FSM encoding for the debug register-access controller.
package reg_access_pkg;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HALT_WAIT = 2'd1,
        S_ACCESS    = 2'd2,
        S_RESP      = 2'd3
    } state_t;

endpackage

// File: rtl/reg_access_if.sv
// Command/response channel between the debug transport (master) and the
// register-access controller (slave).
interface reg_access_if;
    import reg_access_pkg::*;

    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [XLEN-1:0] cmd_data;
    logic [AW-1:0]   cmd_count;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/reg_access_halt_timer.sv
// Halt-wait timer: counts enabled cycles from zero and flags when the count
// reaches HALT_TIMEOUT-1. Saturates there until cleared.
module reg_access_halt_timer #(
    parameter int HALT_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(HALT_TIMEOUT);

    logic [CW-1:0] count;

    assign expired = (count == CW'(HALT_TIMEOUT - 1));

    // Count while enabled; clear restarts from zero for the next halt attempt.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/reg_access_ctrl.sv
// Debug-side register file initiator. Takes one read/write command, halts the
// core, performs a single regfile access, then returns a response.
// Optional feature macro: REG_ACCESS_BURST_EN (repeat the access over
// consecutive registers using cmd_count, one response per access).
module reg_access_ctrl
    import reg_access_pkg::*;
#(
    parameter int HALT_TIMEOUT = 64
) (
    input  logic            clk_Regs,
    input  logic            rst_Regs,
    reg_access_if.slave     bus,
    output logic            halt_req,
    input  logic            halted,
    output logic            Reg_Write,
    output logic [AW-1:0]   W_Addr,
    output logic [XLEN-1:0] W_Data,
    output logic [AW-1:0]   R_Addr_A,
    input  logic [XLEN-1:0] R_Data_A
);

    state_t          state;
    state_t          next_state;

    logic            op_write;
    logic [AW-1:0]   op_addr;
    logic [XLEN-1:0] op_data;
    logic [XLEN-1:0] rsp_data_q;
    logic            rsp_err_q;

    logic            timer_expired;
    logic            burst_more;
    logic            burst_overflow;
    logic [AW-1:0]   access_addr;

`ifdef REG_ACCESS_BURST_EN
    logic [AW-1:0]   op_count;

    // Another access follows only if accesses remain and the address can
    // still advance; at x31 the burst stops and that response is flagged.
    assign burst_more     = (op_count != '0) && (op_addr != '1);
    assign burst_overflow = (op_count != '0) && (op_addr == '1);
`else
    assign burst_more     = 1'b0;
    assign burst_overflow = 1'b0;
`endif

    // Address for the upcoming access: the next register when a burst
    // continues straight from RESP, otherwise the latched command address.
    assign access_addr = (state == S_RESP) ? (op_addr + AW'(1)) : op_addr;

    reg_access_halt_timer #(
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_halt_timer (
        .clk     (clk_Regs),
        .rst     (rst_Regs),
        .clr     (state != S_HALT_WAIT),
        .en      (state == S_HALT_WAIT),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk_Regs) begin
        if (rst_Regs) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. halted wins over the timeout on the final wait cycle.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) next_state = S_HALT_WAIT;
            end
            S_HALT_WAIT: begin
                if (halted)             next_state = S_ACCESS;
                else if (timer_expired) next_state = S_RESP;
            end
            S_ACCESS: begin
                next_state = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) next_state = burst_more ? S_ACCESS : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Moore outputs. Writes to x0 are suppressed here and reported as errors.
    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        halt_req      = (state != S_IDLE);
        Reg_Write     = (state == S_ACCESS) && op_write && (op_addr != '0);
    end

    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;

    // Command latch and response capture.
    always_ff @(posedge clk_Regs) begin
        if (rst_Regs) begin
            op_write   <= 1'b0;
            op_addr    <= '0;
            op_data    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef REG_ACCESS_BURST_EN
            op_count   <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_write <= bus.cmd_write;
                        op_addr  <= bus.cmd_addr;
                        op_data  <= bus.cmd_data;
`ifdef REG_ACCESS_BURST_EN
                        op_count <= bus.cmd_count;
`endif
                    end
                end
                S_HALT_WAIT: begin
                    if (!halted && timer_expired) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
`ifdef REG_ACCESS_BURST_EN
                        // A timed-out command never continues as a burst.
                        op_count   <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (op_write) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= (op_addr == '0) || burst_overflow;
                    end else begin
                        rsp_data_q <= R_Data_A;
                        rsp_err_q  <= burst_overflow;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b0;
`ifdef REG_ACCESS_BURST_EN
                        if (burst_more) begin
                            op_addr  <= op_addr + AW'(1);
                            op_count <= op_count - AW'(1);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Regfile address/data registers change only when an access begins, so
    // they hold their last value between accesses.
    always_ff @(posedge clk_Regs) begin
        if (rst_Regs) begin
            W_Addr   <= '0;
            W_Data   <= '0;
            R_Addr_A <= '0;
        end else if (next_state == S_ACCESS && state != S_ACCESS) begin
            if (op_write) begin
                W_Addr <= access_addr;
                W_Data <= op_data;
            end else begin
                R_Addr_A <= access_addr;
            end
        end
    end

endmodule
